// File: rtl/decode_stage_pkg.sv
// Shared encodings, ALU one-hot bit positions and the ID->EXE bus layout
// for the decode stage and its branch unit.
package decode_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // REGIMM rt codes and COP0 rs codes
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RS_MFC0    = 5'h00;
    localparam logic [4:0] RS_MTC0    = 5'h04;
    localparam logic [25:0] ERET_CODE = 26'h200_0018;

    // alu_control one-hot bit positions
    localparam int ALU_W    = 12;
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    // Bus field widths
    localparam int MULDIV_W   = 2;
    localparam int MEMCTL_W   = 4;
    localparam int CP0ADDR_W  = 8;
    localparam int JBR_W      = 33;
    localparam int ID_EXE_W   = 168;

    typedef struct packed {
        logic beq;
        logic bne;
        logic bgez;
        logic bgtz;
        logic blez;
        logic bltz;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
    } jbr_ops_t;

    // Field order is MSB-first on the ID->EXE bus
    typedef struct packed {
        logic [MULDIV_W-1:0]  muldiv;
        logic                 mthi;
        logic                 mtlo;
        logic [ALU_W-1:0]     alu_control;
        logic [31:0]          alu_operand1;
        logic [31:0]          alu_operand2;
        logic [MEMCTL_W-1:0]  mem_control;
        logic [31:0]          store_data;
        logic                 mfhi;
        logic                 mflo;
        logic                 mtc0;
        logic                 mfc0;
        logic [CP0ADDR_W-1:0] cp0r_addr;
        logic                 syscall;
        logic                 eret;
        logic                 rf_wen;
        logic [4:0]           rf_wdest;
        logic [31:0]          pc;
    } id_exe_t;

    // A source register conflicts when a later stage still owes it a write
    function automatic logic reg_pending(input logic [4:0] r,
                                         input logic [4:0] exe_w,
                                         input logic [4:0] mem_w,
                                         input logic [4:0] wb_w);
        return (r != 5'd0) && ((r == exe_w) || (r == mem_w) || (r == wb_w));
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Branch/jump condition evaluation and target address generation.
module branch_unit
    import decode_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] index,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  jbr_ops_t    ops,
    output logic        is_jbr,
    output logic        condition,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic        rs_zero;
    logic        rs_neg;
    logic        rs_eq_rt;

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{imm[15]}}, imm, 2'b00};
    assign rs_zero   = (rs_value == 32'd0);
    assign rs_neg    = rs_value[31];
    assign rs_eq_rt  = (rs_value == rt_value);

    assign is_jbr = |ops;

    assign condition = (ops.beq  &  rs_eq_rt)
                     | (ops.bne  & ~rs_eq_rt)
                     | (ops.bgez & ~rs_neg)
                     | (ops.bgtz & ~rs_neg & ~rs_zero)
                     | (ops.blez & (rs_neg | rs_zero))
                     | (ops.bltz &  rs_neg)
                     | ops.j | ops.jal | ops.jr | ops.jalr;

    // NOTE: every path assigns target first, so no latch can be inferred.
    always_comb begin
        target = pc_plus4 + br_offset;
        if (ops.j || ops.jal) begin
            target = {pc_plus4[31:28], index, 2'b00};
        end else if (ops.jr || ops.jalr) begin
            target = rs_value;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: control decode, operand selection, hazard
// stall, branch resolution and the packed ID->EXE bus.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                ID_valid,
    input  logic [63:0]         IF_ID_bus_r,
    input  logic [31:0]         rs_value,
    input  logic [31:0]         rt_value,
    input  logic                IF_over,
    input  logic [4:0]          EXE_wdest,
    input  logic [4:0]          MEM_wdest,
    input  logic [4:0]          WB_wdest,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [JBR_W-1:0]    jbr_bus,
    output logic                ID_over,
    output logic [ID_EXE_W-1:0] ID_EXE_bus,
    output logic [31:0]         ID_pc,
    output logic [ALU_W-1:0]    debug_alu_control
);

    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] index;

    assign {pc, inst} = IF_ID_bus_r;
    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign sa    = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];
    assign index = inst[25:0];
    assign ID_pc = pc;

    logic special, regimm, cop0;
    assign special = (op == OP_SPECIAL);
    assign regimm  = (op == OP_REGIMM);
    assign cop0    = (op == OP_COP0);

    // SPECIAL group
    logic i_add, i_addu, i_sub, i_subu, i_slt, i_sltu, i_and, i_or, i_xor, i_nor;
    logic i_sll, i_srl, i_sra, i_sllv, i_srlv, i_srav, i_jr, i_jalr;
    logic i_mult, i_div, i_mfhi, i_mflo, i_mthi, i_mtlo, i_syscall;
    assign i_add     = special & (funct == FN_ADD);
    assign i_addu    = special & (funct == FN_ADDU);
    assign i_sub     = special & (funct == FN_SUB);
    assign i_subu    = special & (funct == FN_SUBU);
    assign i_slt     = special & (funct == FN_SLT);
    assign i_sltu    = special & (funct == FN_SLTU);
    assign i_and     = special & (funct == FN_AND);
    assign i_or      = special & (funct == FN_OR);
    assign i_xor     = special & (funct == FN_XOR);
    assign i_nor     = special & (funct == FN_NOR);
    assign i_sll     = special & (funct == FN_SLL);
    assign i_srl     = special & (funct == FN_SRL);
    assign i_sra     = special & (funct == FN_SRA);
    assign i_sllv    = special & (funct == FN_SLLV);
    assign i_srlv    = special & (funct == FN_SRLV);
    assign i_srav    = special & (funct == FN_SRAV);
    assign i_jr      = special & (funct == FN_JR);
    assign i_jalr    = special & (funct == FN_JALR);
    assign i_mult    = special & (funct == FN_MULT);
    assign i_div     = special & (funct == FN_DIV);
    assign i_mfhi    = special & (funct == FN_MFHI);
    assign i_mflo    = special & (funct == FN_MFLO);
    assign i_mthi    = special & (funct == FN_MTHI);
    assign i_mtlo    = special & (funct == FN_MTLO);
    assign i_syscall = special & (funct == FN_SYSCALL);

    // Immediate, memory, branch and coprocessor groups
    logic i_addi, i_addiu, i_slti, i_sltiu, i_andi, i_ori, i_xori, i_lui;
    logic i_lw, i_lb, i_lbu, i_sw, i_sb;
    logic i_beq, i_bne, i_bgez, i_bgtz, i_blez, i_bltz, i_j, i_jal;
    logic i_mfc0, i_mtc0, i_eret;
    assign i_addi  = (op == OP_ADDI);
    assign i_addiu = (op == OP_ADDIU);
    assign i_slti  = (op == OP_SLTI);
    assign i_sltiu = (op == OP_SLTIU);
    assign i_andi  = (op == OP_ANDI);
    assign i_ori   = (op == OP_ORI);
    assign i_xori  = (op == OP_XORI);
    assign i_lui   = (op == OP_LUI);
    assign i_lw    = (op == OP_LW);
    assign i_lb    = (op == OP_LB);
    assign i_lbu   = (op == OP_LBU);
    assign i_sw    = (op == OP_SW);
    assign i_sb    = (op == OP_SB);
    assign i_beq   = (op == OP_BEQ);
    assign i_bne   = (op == OP_BNE);
    assign i_bgtz  = (op == OP_BGTZ);
    assign i_blez  = (op == OP_BLEZ);
    assign i_bgez  = regimm & (rt == RT_BGEZ);
    assign i_bltz  = regimm & (rt == RT_BLTZ);
    assign i_j     = (op == OP_J);
    assign i_jal   = (op == OP_JAL);
    assign i_mfc0  = cop0 & (rs == RS_MFC0);
    assign i_mtc0  = cop0 & (rs == RS_MTC0);
    assign i_eret  = cop0 & (index == ERET_CODE);

    logic r_alu, shift_imm, imm_sext, imm_zext, is_load, is_store, is_link, is_branch;
    assign r_alu     = i_add | i_addu | i_sub | i_subu | i_slt | i_sltu | i_and
                     | i_or | i_xor | i_nor | i_sllv | i_srlv | i_srav;
    assign shift_imm = i_sll | i_srl | i_sra;
    assign imm_sext  = i_addi | i_addiu | i_slti | i_sltiu;
    assign imm_zext  = i_andi | i_ori | i_xori;
    assign is_load   = i_lw | i_lb | i_lbu;
    assign is_store  = i_sw | i_sb;
    assign is_link   = i_jal | i_jalr;
    assign is_branch = i_beq | i_bne | i_bgez | i_bgtz | i_blez | i_bltz;

    logic [ALU_W-1:0] alu_control;
    always_comb begin
        alu_control           = '0;
        alu_control[ALU_ADD]  = i_add | i_addu | i_addi | i_addiu | is_load | is_store | is_link;
        alu_control[ALU_SUB]  = i_sub | i_subu;
        alu_control[ALU_SLT]  = i_slt | i_slti;
        alu_control[ALU_SLTU] = i_sltu | i_sltiu;
        alu_control[ALU_AND]  = i_and | i_andi;
        alu_control[ALU_NOR]  = i_nor;
        alu_control[ALU_OR]   = i_or | i_ori;
        alu_control[ALU_XOR]  = i_xor | i_xori;
        alu_control[ALU_SLL]  = i_sll | i_sllv;
        alu_control[ALU_SRL]  = i_srl | i_srlv;
        alu_control[ALU_SRA]  = i_sra | i_srav;
        alu_control[ALU_LUI]  = i_lui;
    end

    logic [31:0] alu_operand1, alu_operand2;
    always_comb begin
        alu_operand1 = rs_value;
        if (shift_imm)    alu_operand1 = {27'd0, sa};
        else if (is_link) alu_operand1 = pc;

        alu_operand2 = rt_value;
        if (is_link)                            alu_operand2 = 32'd8;
        else if (imm_zext || i_lui)             alu_operand2 = {16'd0, imm};
        else if (imm_sext || is_load || is_store) alu_operand2 = {{16{imm[15]}}, imm};
    end

    // Destination register selection; writes to $0 are dropped
    logic wr_rd, wr_rt;
    logic [4:0] rf_wdest;
    assign wr_rd = r_alu | shift_imm | i_mfhi | i_mflo | i_jalr;
    assign wr_rt = imm_sext | imm_zext | i_lui | is_load | i_mfc0;
    always_comb begin
        rf_wdest = 5'd0;
        if (wr_rd)      rf_wdest = rd;
        else if (wr_rt) rf_wdest = rt;
        else if (i_jal) rf_wdest = 5'd31;
    end

    logic rs_used, rt_used, stall;
    assign rs_used = r_alu | imm_sext | imm_zext | is_load | is_store | is_branch
                   | i_jr | i_jalr | i_mult | i_div | i_mthi | i_mtlo;
    assign rt_used = r_alu | shift_imm | i_beq | i_bne | is_store | i_mult | i_div | i_mtc0;
    assign stall   = (rs_used & reg_pending(rs, EXE_wdest, MEM_wdest, WB_wdest))
                   | (rt_used & reg_pending(rt, EXE_wdest, MEM_wdest, WB_wdest));

    jbr_ops_t    jbr_ops;
    logic        is_jbr, jbr_cond;
    logic [31:0] jbr_target;
    assign jbr_ops = '{beq: i_beq, bne: i_bne, bgez: i_bgez, bgtz: i_bgtz,
                       blez: i_blez, bltz: i_bltz, j: i_j, jal: i_jal,
                       jr: i_jr, jalr: i_jalr};

    branch_unit u_branch_unit (
        .pc        (pc),
        .imm       (imm),
        .index     (index),
        .rs_value  (rs_value),
        .rt_value  (rt_value),
        .ops       (jbr_ops),
        .is_jbr    (is_jbr),
        .condition (jbr_cond),
        .target    (jbr_target)
    );

    // A branch waits for its delay slot to be fetched before leaving decode
    assign ID_over = ID_valid & ~stall & (~is_jbr | IF_over);
    assign jbr_bus = {jbr_cond & ID_valid & ID_over, jbr_target};

    id_exe_t id_exe;
    always_comb begin
        id_exe.muldiv       = {i_mult, i_div};
        id_exe.mthi         = i_mthi;
        id_exe.mtlo         = i_mtlo;
        id_exe.alu_control  = alu_control;
        id_exe.alu_operand1 = alu_operand1;
        id_exe.alu_operand2 = alu_operand2;
        id_exe.mem_control  = {is_load, is_store, i_lw | i_sw, i_lb};
        id_exe.store_data   = rt_value;
        id_exe.mfhi         = i_mfhi;
        id_exe.mflo         = i_mflo;
        id_exe.mtc0         = i_mtc0;
        id_exe.mfc0         = i_mfc0;
        id_exe.cp0r_addr    = {rd, inst[2:0]};
        id_exe.syscall      = i_syscall;
        id_exe.eret         = i_eret;
        id_exe.rf_wen       = (wr_rd | wr_rt | i_jal) & (rf_wdest != 5'd0);
        id_exe.rf_wdest     = rf_wdest;
        id_exe.pc           = pc;
    end
    assign ID_EXE_bus = id_exe;

    // NOTE: sequential state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            debug_alu_control <= '0;
        end else begin
            debug_alu_control <= alu_control;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed vectors.
module tb_decode_stage;

    logic         clk;
    logic         resetn;
    logic         ID_valid;
    logic [63:0]  IF_ID_bus_r;
    logic [31:0]  rs_value;
    logic [31:0]  rt_value;
    logic         IF_over;
    logic [4:0]   EXE_wdest;
    logic [4:0]   MEM_wdest;
    logic [4:0]   WB_wdest;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [32:0]  jbr_bus;
    logic         ID_over;
    logic [167:0] ID_EXE_bus;
    logic [31:0]  ID_pc;
    logic [11:0]  debug_alu_control;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ID_valid          (ID_valid),
        .IF_ID_bus_r       (IF_ID_bus_r),
        .rs_value          (rs_value),
        .rt_value          (rt_value),
        .IF_over           (IF_over),
        .EXE_wdest         (EXE_wdest),
        .MEM_wdest         (MEM_wdest),
        .WB_wdest          (WB_wdest),
        .rs                (rs),
        .rt                (rt),
        .jbr_bus           (jbr_bus),
        .ID_over           (ID_over),
        .ID_EXE_bus        (ID_EXE_bus),
        .ID_pc             (ID_pc),
        .debug_alu_control (debug_alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Bus field slices, taken by hand from the MSB-first layout
    function automatic logic [11:0] f_alu(input logic [167:0] b); return b[163:152]; endfunction
    function automatic logic [31:0] f_op1(input logic [167:0] b); return b[151:120]; endfunction
    function automatic logic [31:0] f_op2(input logic [167:0] b); return b[119:88];  endfunction
    function automatic logic [3:0]  f_mem(input logic [167:0] b); return b[87:84];   endfunction
    function automatic logic [31:0] f_sd (input logic [167:0] b); return b[83:52];   endfunction
    function automatic logic [7:0]  f_cp0(input logic [167:0] b); return b[47:40];   endfunction
    function automatic logic        f_wen(input logic [167:0] b); return b[37];      endfunction
    function automatic logic [4:0]  f_wd (input logic [167:0] b); return b[36:32];   endfunction
    function automatic logic [31:0] f_pc (input logic [167:0] b); return b[31:0];    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rsv, input logic [31:0] rtv);
        @(negedge clk);
        IF_ID_bus_r = {pc, inst};
        rs_value    = rsv;
        rt_value    = rtv;
        #1;
    endtask

    initial begin
        resetn      = 1'b1;
        ID_valid    = 1'b1;
        IF_ID_bus_r = '0;
        rs_value    = '0;
        rt_value    = '0;
        IF_over     = 1'b1;
        EXE_wdest   = 5'd0;
        MEM_wdest   = 5'd0;
        WB_wdest    = 5'd0;
        #1 resetn = 1'b0;
        #1;
        check("reset_debug", 64'(debug_alu_control), 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ADD $2,$21,$10
        drive(32'h34, {6'h00, 5'd21, 5'd10, 5'd2, 5'd0, 6'h20}, 32'd16, 32'd32);
        check("add_alu",   64'(f_alu(ID_EXE_bus)), 64'h800);
        check("add_op1",   64'(f_op1(ID_EXE_bus)), 64'd16);
        check("add_op2",   64'(f_op2(ID_EXE_bus)), 64'd32);
        check("add_wen",   64'(f_wen(ID_EXE_bus)), 64'd1);
        check("add_wdest", 64'(f_wd(ID_EXE_bus)),  64'd2);
        check("add_over",  64'(ID_over),           64'd1);
        check("add_idpc",  64'(ID_pc),             64'h34);
        check("add_buspc", 64'(f_pc(ID_EXE_bus)),  64'h34);
        check("add_taken", 64'(jbr_bus[32]),       64'd0);
        check("add_rs_rt", 64'({rs, rt}),          64'({5'd21, 5'd10}));

        // Hazards against rs, rt, and a non-source register
        EXE_wdest = 5'd21; #1;
        check("haz_exe_rs", 64'(ID_over), 64'd0);
        EXE_wdest = 5'd0; WB_wdest = 5'd10; #1;
        check("haz_wb_rt", 64'(ID_over), 64'd0);
        WB_wdest = 5'd0; MEM_wdest = 5'd2; #1;
        check("haz_dest_only", 64'(ID_over), 64'd1);
        MEM_wdest = 5'd0; ID_valid = 1'b0; #1;
        check("invalid_over", 64'(ID_over), 64'd0);
        ID_valid = 1'b1;

        // ADD with rd=0 must not write
        drive(32'h38, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'd1, 32'd2);
        check("add_rd0_wen", 64'(f_wen(ID_EXE_bus)), 64'd0);

        // Register-debug path: one edge loads, async reset clears at once
        drive(32'h34, {6'h00, 5'd21, 5'd10, 5'd2, 5'd0, 6'h20}, 32'd16, 32'd32);
        @(posedge clk);
        #1;
        check("debug_load", 64'(debug_alu_control), 64'h800);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("debug_async_clr", 64'(debug_alu_control), 64'h0);
        check("comb_in_reset",   64'(f_alu(ID_EXE_bus)), 64'h800);
        @(negedge clk);
        resetn = 1'b1;

        // BEQ $1,$2,+4 at 0x100, waiting for delay slot then taken
        IF_over = 1'b0;
        drive(32'h100, {6'h04, 5'd1, 5'd2, 16'd4}, 32'd5, 32'd5);
        check("beq_wait_over",  64'(ID_over),     64'd0);
        check("beq_wait_taken", 64'(jbr_bus[32]), 64'd0);
        IF_over = 1'b1; #1;
        check("beq_taken", 64'(jbr_bus), 64'h1_0000_0114);

        drive(32'h100, {6'h05, 5'd1, 5'd2, 16'd4}, 32'd5, 32'd5);
        check("bne_not_taken", 64'(jbr_bus[32]), 64'd0);
        check("bne_over",      64'(ID_over),     64'd1);

        // BLTZ with negative offset, then BGTZ on zero
        drive(32'h100, {6'h01, 5'd3, 5'd0, 16'hFFFE}, 32'h8000_0000, 32'd0);
        check("bltz_taken", 64'(jbr_bus), 64'h1_0000_00FC);
        drive(32'h100, {6'h07, 5'd3, 5'd0, 16'd8}, 32'd0, 32'd0);
        check("bgtz_zero", 64'(jbr_bus[32]), 64'd0);

        // JAL at 0x0040_0000
        drive(32'h0040_0000, {6'h03, 26'h10}, 32'd0, 32'd0);
        check("jal_bus",   64'(jbr_bus),           64'h1_0000_0040);
        check("jal_wdest", 64'(f_wd(ID_EXE_bus)),  64'd31);
        check("jal_wen",   64'(f_wen(ID_EXE_bus)), 64'd1);
        check("jal_op1",   64'(f_op1(ID_EXE_bus)), 64'h0040_0000);
        check("jal_op2",   64'(f_op2(ID_EXE_bus)), 64'd8);
        check("jal_alu",   64'(f_alu(ID_EXE_bus)), 64'h800);

        // JR $31, then stalled on a pending $31
        drive(32'h200, {6'h00, 5'd31, 15'd0, 6'h08}, 32'hBFC0_0380, 32'd0);
        check("jr_bus", 64'(jbr_bus), 64'h1_BFC0_0380);
        EXE_wdest = 5'd31; #1;
        check("jr_stall_over",  64'(ID_over),     64'd0);
        check("jr_stall_taken", 64'(jbr_bus[32]), 64'd0);
        EXE_wdest = 5'd0;

        // LUI $3,0xFFFF
        drive(32'h40, {6'h0F, 5'd0, 5'd3, 16'hFFFF}, 32'd0, 32'd0);
        check("lui_alu",   64'(f_alu(ID_EXE_bus)), 64'h001);
        check("lui_op2",   64'(f_op2(ID_EXE_bus)), 64'h0000_FFFF);
        check("lui_wdest", 64'(f_wd(ID_EXE_bus)),  64'd3);

        // SW $6,-4($4)
        drive(32'h44, {6'h2B, 5'd4, 5'd6, 16'hFFFC}, 32'h1000, 32'hDEAD_BEEF);
        check("sw_mem",   64'(f_mem(ID_EXE_bus)), 64'b0110);
        check("sw_wen",   64'(f_wen(ID_EXE_bus)), 64'd0);
        check("sw_sdata", 64'(f_sd(ID_EXE_bus)),  64'hDEAD_BEEF);
        check("sw_op2",   64'(f_op2(ID_EXE_bus)), 64'hFFFF_FFFC);
        check("sw_alu",   64'(f_alu(ID_EXE_bus)), 64'h800);

        // LB $7,0($4)
        drive(32'h48, {6'h20, 5'd4, 5'd7, 16'd0}, 32'h1000, 32'd0);
        check("lb_mem",   64'(f_mem(ID_EXE_bus)), 64'b1001);
        check("lb_wdest", 64'(f_wd(ID_EXE_bus)),  64'd7);

        // SLL $4,$5,7
        drive(32'h4C, {6'h00, 5'd0, 5'd5, 5'd4, 5'd7, 6'h00}, 32'hFFFF_FFFF, 32'h1234);
        check("sll_alu", 64'(f_alu(ID_EXE_bus)), 64'h008);
        check("sll_op1", 64'(f_op1(ID_EXE_bus)), 64'd7);
        check("sll_op2", 64'(f_op2(ID_EXE_bus)), 64'h1234);

        // MULT $8,$9 and MFC0 $8,$12
        drive(32'h50, {6'h00, 5'd8, 5'd9, 10'd0, 6'h18}, 32'd3, 32'd4);
        check("mult_muldiv", 64'(ID_EXE_bus[167:166]), 64'b10);
        check("mult_wen",    64'(f_wen(ID_EXE_bus)),    64'd0);
        drive(32'h54, {6'h10, 5'd0, 5'd8, 5'd12, 8'd0, 3'd0}, 32'd0, 32'd0);
        check("mfc0_flag",  64'(ID_EXE_bus[48]),    64'd1);
        check("mfc0_cp0r",  64'(f_cp0(ID_EXE_bus)), 64'h60);
        check("mfc0_wdest", 64'(f_wd(ID_EXE_bus)),  64'd8);

        // Unlisted opcode decodes as NOP
        drive(32'h58, {6'h3F, 26'h3FF_FFFF}, 32'd1, 32'd2);
        check("nop_alu",  64'(f_alu(ID_EXE_bus)),   64'h0);
        check("nop_ctl",  64'(ID_EXE_bus[167:164]), 64'h0);
        check("nop_wen",  64'(f_wen(ID_EXE_bus)),   64'd0);
        check("nop_mem",  64'(f_mem(ID_EXE_bus)),   64'h0);
        check("nop_over", 64'(ID_over),             64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  stage clock; one clock only.
REQ-002 resetn  input  1  reset; asynchronous, active-low.
REQ-003 ID_valid  input  1  ID stage holds a valid instruction.
REQ-004 IF_ID_bus_r  input  64  {pc[31:0], inst[31:0]} from IF latch.
REQ-005 rs_value / rt_value  input  32 each  register-file read data for rs/rt.
REQ-006 IF_over  input  1  IF has completed fetch of the next (delay-slot) instruction.
REQ-007 EXE_wdest / MEM_wdest / WB_wdest  input  5 each  pending destination register in that stage; 0 = none.
REQ-008 rs / rt  output  5 each  inst[25:21] / inst[20:16] to register file.
REQ-009 jbr_bus  output  33  {jbr_taken, jbr_target[31:0]}.
REQ-010 ID_over  output  1  decode complete, may advance to EXE.
REQ-011 ID_EXE_bus  output  168  MSB-first: muldiv[2], mthi, mtlo, alu_control[12], alu_operand1[32], alu_operand2[32], mem_control[4], store_data[32], mfhi, mflo, mtc0, mfc0, cp0r_addr[8], syscall, eret, rf_wen, rf_wdest[5], pc[32].
REQ-012 ID_pc  output  32  pc field of IF_ID_bus_r.
REQ-013 debug_alu_control  output  12  registered copy of alu_control.

Function
REQ-014 All outputs except debug_alu_control SHALL be combinational from current inputs (zero latency).
REQ-015 Decoded set: ADD ADDU SUB SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LW LB LBU SW SB BEQ BNE BGEZ BGTZ BLEZ BLTZ J JAL JR JALR MULT DIV MFHI MFLO MTHI MTLO MFC0 MTC0 SYSCALL ERET; unlisted encodings decode as NOP (all controls 0).
REQ-016 alu_control one-hot, bit11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
REQ-017 alu_operand1: sa (zero-extended) for SLL/SRL/SRA, pc for JAL/JALR, else rs_value.
REQ-018 alu_operand2: 8 for JAL/JALR; zero-extended imm for ANDI/ORI/XORI/LUI; sign-extended imm for other I-type ALU, loads, stores; else rt_value.
REQ-019 Loads/stores use add; mem_control = {load, store, word, load_sign}; store_data = rt_value.
REQ-020 muldiv = {mult, div}; mfhi/mflo/mthi/mtlo/mtc0/mfc0/syscall/eret flags set per instruction; cp0r_addr = {inst[15:11], inst[2:0]}.
REQ-021 rf_wdest: rd for R-type writers and JALR; rt for I-type ALU, LUI, loads, MFC0; 31 for JAL; rf_wen = 1 for these only, and forced 0 when rf_wdest = 0.
REQ-022 Branch target = pc+4 + (sext(imm)<<2); J/JAL target = {pc_plus4[31:28], index, 2'b00}; JR/JALR target = rs_value.
REQ-023 Conditions: BEQ rs=rt, BNE rs≠rt, BGEZ rs≥0, BGTZ rs>0, BLEZ rs≤0, BLTZ rs<0 (signed); jumps always; jbr_taken = condition & ID_valid & ID_over.
REQ-024 Hazard: stall when an operand actually used (rs or rt) is nonzero and equals any of EXE/MEM/WB_wdest.
REQ-025 ID_over = ID_valid & ~stall & (~jump_or_branch | IF_over).
REQ-026 ID_pc = IF_ID_bus_r[63:32]; pc field of ID_EXE_bus = same pc.
REQ-027 debug_alu_control SHALL load alu_control every rising clk edge.

Reset
REQ-028 resetn low SHALL clear debug_alu_control to 0 immediately, independent of clk; combinational outputs unaffected.

Structure
REQ-029 Opcode/funct constants, alu_control bit indices and ID_EXE_bus field widths SHALL live in a shared package.
REQ-030 One sub-module, branch_unit (condition compare + target calc), is natural; remaining logic flat.

Verification
REQ-031 pc=0x34, inst ADD rs=21 rt=10 rd=2, rs_value=16, rt_value=32, wdests 0, IF_over=1 -> alu_control=0x800, operand1=16, operand2=32, rf_wen=1, rf_wdest=2, ID_over=1, ID_pc=0x34, jbr_taken=0.
REQ-032 Same ADD with EXE_wdest=21 -> ID_over=0; with EXE_wdest=0, WB_wdest=10 -> ID_over=0.
REQ-033 BEQ at pc=0x100, imm=4, rs_value=rt_value=5, IF_over=0 -> ID_over=0, jbr_taken=0; IF_over=1 -> jbr_bus={1,0x114}.
REQ-034 JAL at pc=0x0040_0000, index=0x10 -> target 0x0000_0040, rf_wdest=31, operand1=pc, operand2=8, alu add.
REQ-035 LUI rt=3 imm=0xFFFF -> alu_control lui bit, operand2=0x0000FFFF, rf_wdest=3; SW -> mem_control=4'b0110, rf_wen=0.
REQ-036 Apply ADD, clock once -> debug_alu_control=0x800; drop resetn between edges -> 0 at once.
